// File: rtl/tri_raster_scan.sv
// Triangle bounding-box raster scanner: walks every point of the vertex bounding box
// row-major, hands each point to an external point-test responder, and reports the inside
// points. Optional screen clipping is enabled by defining RASTER_CLIP_EN.
module tri_raster_scan #(
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] p1x,
  input  logic [10:0] p1y,
  input  logic [10:0] p2x,
  input  logic [10:0] p2y,
  input  logic [10:0] p3x,
  input  logic [10:0] p3y,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [10:0] ptx,
  output logic [10:0] pty,
  input  logic        rsp_valid,
  input  logic        rsp_inside,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [22:0] inside_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BBOX  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef RASTER_CLIP_EN
  localparam logic [10:0] X_LIM = 11'(SCR_W - 1);
  localparam logic [10:0] Y_LIM = 11'(SCR_H - 1);
`endif

  function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                       input logic [10:0] c);
    logic [10:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                       input logic [10:0] c);
    logic [10:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_t      state_q, state_d;
  logic [10:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic [10:0] v1x_d, v1y_d, v2x_d, v2y_d, v3x_d, v3y_d;
  logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [10:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [10:0] ptx_q, pty_q, ptx_d, pty_d;
  logic [10:0] pix_x_q, pix_y_q, pix_x_d, pix_y_d;
  logic        pix_valid_q, pix_valid_d;
  logic        busy_q, busy_d, done_q, done_d, req_valid_q, req_valid_d;
  logic [22:0] cnt_q, cnt_d;
  logic [10:0] bx_lo, bx_hi, by_lo, by_hi;
  logic        clip_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      v1x_q       <= 11'd0;
      v1y_q       <= 11'd0;
      v2x_q       <= 11'd0;
      v2y_q       <= 11'd0;
      v3x_q       <= 11'd0;
      v3y_q       <= 11'd0;
      xmin_q      <= 11'd0;
      xmax_q      <= 11'd0;
      ymin_q      <= 11'd0;
      ymax_q      <= 11'd0;
      ptx_q       <= 11'd0;
      pty_q       <= 11'd0;
      pix_x_q     <= 11'd0;
      pix_y_q     <= 11'd0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      cnt_q       <= 23'd0;
    end else begin
      state_q     <= state_d;
      v1x_q       <= v1x_d;
      v1y_q       <= v1y_d;
      v2x_q       <= v2x_d;
      v2y_q       <= v2y_d;
      v3x_q       <= v3x_d;
      v3y_q       <= v3y_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      ptx_q       <= ptx_d;
      pty_q       <= pty_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    v1x_d       = v1x_q;
    v1y_d       = v1y_q;
    v2x_d       = v2x_q;
    v2y_d       = v2y_q;
    v3x_d       = v3x_q;
    v3y_d       = v3y_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    ptx_d       = ptx_q;
    pty_d       = pty_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = 1'b0;
    cnt_d       = cnt_q;

    bx_lo = min3(v1x_q, v2x_q, v3x_q);
    bx_hi = max3(v1x_q, v2x_q, v3x_q);
    by_lo = min3(v1y_q, v2y_q, v3y_q);
    by_hi = max3(v1y_q, v2y_q, v3y_q);
`ifdef RASTER_CLIP_EN
    // A box starting off-screen has nothing visible to scan.
    clip_out = (bx_lo > X_LIM) || (by_lo > Y_LIM);
    if (bx_hi > X_LIM) bx_hi = X_LIM;
    else bx_hi = bx_hi;
    if (by_hi > Y_LIM) by_hi = Y_LIM;
    else by_hi = by_hi;
`else
    clip_out = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          v1x_d   = p1x;
          v1y_d   = p1y;
          v2x_d   = p2x;
          v2y_d   = p2y;
          v3x_d   = p3x;
          v3y_d   = p3y;
          cnt_d   = 23'd0;
          state_d = BBOX;
        end else begin
          state_d = IDLE;
        end
      end
      BBOX: begin
        xmin_d = bx_lo;
        xmax_d = bx_hi;
        ymin_d = by_lo;
        ymax_d = by_hi;
        ptx_d  = bx_lo;
        pty_d  = by_lo;
        if (clip_out) state_d = DONE;
        else state_d = ISSUE;
      end
      ISSUE: begin
        if (req_ready) state_d = WAIT;
        else state_d = ISSUE;
      end
      WAIT: begin
        if (rsp_valid) begin
          if (rsp_inside) begin
            pix_valid_d = 1'b1;
            pix_x_d     = ptx_q;
            pix_y_d     = pty_q;
            cnt_d       = cnt_q + 23'd1;
          end else begin
            pix_valid_d = 1'b0;
          end
          if (ptx_q == xmax_q) begin
            ptx_d = xmin_q;
            if (pty_q == ymax_q) begin
              state_d = DONE;
            end else begin
              pty_d   = pty_q + 11'd1;
              state_d = ISSUE;
            end
          end else begin
            ptx_d   = ptx_q + 11'd1;
            state_d = ISSUE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flag outputs are registered copies of the upcoming state.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    req_valid_d = (state_d == ISSUE);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign req_valid    = req_valid_q;
  assign ptx          = ptx_q;
  assign pty          = pty_q;
  assign pix_valid    = pix_valid_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign inside_count = cnt_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
// Scoreboard bench for tri_raster_scan: a responder answers point requests and queues the
// expected pixel reports, a monitor pops and checks them; directed triangles with known boxes.
module tb_tri_raster_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic        start, req_ready, rsp_valid, rsp_inside;
  logic        busy, done, req_valid, pix_valid;
  logic [10:0] ptx, pty, pix_x, pix_y;
  logic [22:0] inside_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] req_exp_q[$];
  logic [21:0] pix_exp_q[$];
  int  req_cnt = 0, done_cnt = 0, pix_cnt = 0, exp_inside = 0, cnt78 = 0;
  logic [21:0] last_pt = 22'd0;
  logic resp_en = 1'b1, resp_mode = 1'b0, inject = 1'b0;

  tri_raster_scan dut (
    .clk(clk), .rst(rst),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .ptx(ptx), .pty(pty),
    .rsp_valid(rsp_valid), .rsp_inside(rsp_inside),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .inside_count(inside_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference point-in-triangle test for (1,6),(4,14),(17,5), edges count as inside.
  function automatic logic pit(input int x, input int y);
    int e1, e2, e3;
    e1 = (4 - 1) * (y - 6) - (14 - 6) * (x - 1);
    e2 = (17 - 4) * (y - 14) - (5 - 14) * (x - 4);
    e3 = (1 - 17) * (y - 5) - (6 - 5) * (x - 17);
    return ((e1 >= 0) && (e2 >= 0) && (e3 >= 0)) || ((e1 <= 0) && (e2 <= 0) && (e3 <= 0));
  endfunction

  // Responder: answers one cycle after each accepted request and queues expected pixels.
  initial begin
    logic pending, pend_in;
    pending = 1'b0;
    pend_in = 1'b0;
    rsp_valid = 1'b0;
    rsp_inside = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_inside = 1'b0;
      if (inject) begin
        rsp_valid = 1'b1;
        rsp_inside = 1'b1;
      end else if (pending) begin
        rsp_valid = 1'b1;
        rsp_inside = pend_in;
        pending = 1'b0;
      end
      if (resp_en && req_valid && req_ready && !rst) begin
        if (req_exp_q.size() == 0) check("req_unexpected", {ptx, pty}, 64'd0);
        else check("req_point", {ptx, pty}, req_exp_q.pop_front());
        req_cnt++;
        last_pt = {ptx, pty};
        pend_in = resp_mode ? pit(int'(ptx), int'(pty)) : 1'b1;
        pending = 1'b1;
        if (pend_in) begin
          pix_exp_q.push_back({ptx, pty});
          exp_inside++;
        end
      end
    end
  end

  // Monitor: checks every pixel report against the scoreboard and counts done pulses.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        pix_cnt++;
        if (pix_exp_q.size() == 0) begin
          check("pix_unexpected", {pix_x, pix_y}, 64'd0);
        end else begin
          e = pix_exp_q.pop_front();
          check("pix_point", {pix_x, pix_y}, e);
          if ({pix_x, pix_y} == {11'd7, 11'd8}) cnt78++;
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        req_exp_q.push_back({11'(x), 11'(y)});
  endtask

  task automatic do_start(input logic [10:0] ax, input logic [10:0] ay, input logic [10:0] bx,
                          input logic [10:0] by, input logic [10:0] cx, input logic [10:0] cy);
    @(negedge clk);
    p1x = ax; p1y = ay; p2x = bx; p2y = by; p3x = cx; p3y = cy;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    check("scan_terminates_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_flags"}, {60'd0, busy, done, req_valid, pix_valid}, 64'd0);
    check({name, "_data"}, {ptx, pty, pix_x, pix_y}, 64'd0);
    check({name, "_count"}, 64'(inside_count), 64'd0);
  endtask

  initial begin
    int b_req, b_done, b_pix, b_in, b_78;
    rst = 1'b1; start = 1'b0; req_ready = 1'b1;
    p1x = 11'd0; p1y = 11'd0; p2x = 11'd0; p2y = 11'd0; p3x = 11'd0; p3y = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Every point reported inside: full 17x10 box, start ignored mid-scan.
    resp_mode = 1'b0;
    push_rect(1, 17, 5, 14);
    b_req = req_cnt; b_done = done_cnt; b_pix = pix_cnt;
    do_start(11'd1, 11'd6, 11'd4, 11'd14, 11'd17, 11'd5);
    check("bbox_busy", 64'(busy), 64'd1);
    check("bbox_req_valid", 64'(req_valid), 64'd0);
    @(posedge clk);
    #1;
    check("first_req_valid", 64'(req_valid), 64'd1);
    check("first_point", {ptx, pty}, {11'd1, 11'd5});
    repeat (20) @(posedge clk);
    @(negedge clk);
    p1x = 11'd100; p2x = 11'd200; p3x = 11'd300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);
    check("all_in_requests", 64'(req_cnt - b_req), 64'd170);
    check("all_in_last", 64'(last_pt), {11'd17, 11'd14});
    check("all_in_count", 64'(inside_count), 64'd170);
    check("all_in_pix_pulses", 64'(pix_cnt - b_pix), 64'd170);
    check("all_in_done_pulses", 64'(done_cnt - b_done), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("count_holds", 64'(inside_count), 64'd170);

    // True point-in-triangle responder.
    resp_mode = 1'b1;
    push_rect(1, 17, 5, 14);
    b_req = req_cnt; b_pix = pix_cnt; b_in = exp_inside; b_78 = cnt78;
    do_start(11'd1, 11'd6, 11'd4, 11'd14, 11'd17, 11'd5);
    wait_idle(2000);
    check("pit_requests", 64'(req_cnt - b_req), 64'd170);
    check("pit_count", 64'(inside_count), 64'(exp_inside - b_in));
    check("pit_pulses_vs_count", 64'(pix_cnt - b_pix), 64'(inside_count));
    check("pit_7_8_reported", 64'(cnt78 - b_78), 64'd1);
    check("pit_queue_empty", 64'(pix_exp_q.size()), 64'd0);

    // Degenerate triangle with a stalled responder.
    resp_mode = 1'b0;
    req_exp_q.push_back({11'd3, 11'd3});
    b_req = req_cnt; b_done = done_cnt;
    @(negedge clk);
    req_ready = 1'b0;
    do_start(11'd3, 11'd3, 11'd3, 11'd3, 11'd3, 11'd3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_point", {req_valid, ptx, pty}, {1'b1, 11'd3, 11'd3});
      @(posedge clk);
      #1;
    end
    req_ready = 1'b1;
    wait_idle(100);
    check("degen_requests", 64'(req_cnt - b_req), 64'd1);
    check("degen_done", 64'(done_cnt - b_done), 64'd1);
    check("degen_count", 64'(inside_count), 64'd1);

    // Reset with a request outstanding, then a stale response.
    resp_en = 1'b0;
    b_done = done_cnt; b_pix = pix_cnt;
    do_start(11'd1, 11'd1, 11'd5, 11'd5, 11'd2, 11'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("wait_state", {busy, req_valid}, {1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("stale_rsp");
    check("stale_no_done", 64'(done_cnt - b_done), 64'd0);
    check("stale_no_pix", 64'(pix_cnt - b_pix), 64'd0);
    resp_en = 1'b1;

`ifdef RASTER_CLIP_EN
    push_rect(630, 639, 0, 1);
    b_req = req_cnt;
    do_start(11'd630, 11'd0, 11'd700, 11'd0, 11'd630, 11'd1);
    wait_idle(200);
    check("clip_requests", 64'(req_cnt - b_req), 64'd20);
    check("clip_last", 64'(last_pt), {11'd639, 11'd1});
    b_req = req_cnt; b_done = done_cnt;
    do_start(11'd700, 11'd0, 11'd710, 11'd0, 11'd705, 11'd5);
    check("offscreen_done_early", {busy, done}, {1'b1, 1'b0});
    @(posedge clk);
    #1;
    check("offscreen_done", {done, req_valid}, {1'b1, 1'b0});
    wait_idle(20);
    check("offscreen_requests", 64'(req_cnt - b_req), 64'd0);
    check("offscreen_done_pulses", 64'(done_cnt - b_done), 64'd1);
`else
    push_rect(2045, 2047, 2046, 2047);
    b_req = req_cnt;
    do_start(11'd2045, 11'd2046, 11'd2047, 11'd2047, 11'd2047, 11'd2046);
    wait_idle(200);
    check("corner_requests", 64'(req_cnt - b_req), 64'd6);
    check("corner_last", 64'(last_pt), {11'd2047, 11'd2047});
    check("corner_count", 64'(inside_count), 64'd6);
`endif
    repeat (3) @(posedge clk);
    check("req_queue_drained", 64'(req_exp_q.size()), 64'd0);
    check("pix_queue_drained", 64'(pix_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_raster_scan.md
TRI_RASTER_SCAN -- requirements
Module: tri_raster_scan

Interface
REQ-001 SHALL have parameter SCR_W, default 640, screen width in pixels (used only with RASTER_CLIP_EN).
REQ-002 SHALL have parameter SCR_H, default 480, screen height in pixels (used only with RASTER_CLIP_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports p1x,p1y,p2x,p2y,p3x,p3y  input  11 each  unsigned triangle vertices, sampled on start acceptance.
REQ-006 SHALL have port start  input  1  begin a scan; accepted only in IDLE.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse at scan end.
REQ-009 SHALL have ports req_valid  output  1 and req_ready  input  1  candidate-point handshake to the point-test responder.
REQ-010 SHALL have ports ptx,pty  output  11 each  candidate point, stable while req_valid is high and req_ready is low.
REQ-011 SHALL have ports rsp_valid  input  1 and rsp_inside  input  1  responder result; rsp_inside qualified by rsp_valid.
REQ-012 SHALL have ports pix_valid  output  1 and pix_x,pix_y  output  11 each  one-cycle pulse per inside point.
REQ-013 SHALL have port inside_count  output  23  number of inside points in current/last scan.

Function
REQ-014 SHALL implement FSM states IDLE, BBOX, ISSUE, WAIT, DONE.
REQ-015 IDLE: start=1 -> latch vertices, clear inside_count, go BBOX; start in any other state SHALL be ignored.
REQ-016 BBOX (1 cycle): compute xmin,xmax,ymin,ymax as unsigned min/max of the three vertices; load ptx=xmin, pty=ymin; go ISSUE.
REQ-017 ISSUE: req_valid=1; req_valid SHALL first assert 2 cycles after the start-accept edge; on req_valid&&req_ready go WAIT, req_valid low next cycle.
REQ-018 At most one request outstanding; rsp_valid outside WAIT SHALL be ignored.
REQ-019 WAIT: on rsp_valid, if rsp_inside then next cycle pix_valid=1, pix_x/pix_y = tested point, inside_count += 1.
REQ-020 Scan order row-major: x increments; after x==xmax, x wraps to xmin and y increments; after (xmax,ymax) response go DONE, else go ISSUE.
REQ-021 DONE (1 cycle): done=1, go IDLE; inside_count SHALL hold until next accepted start.
REQ-022 Degenerate triangle (all vertices equal) SHALL issue exactly one request.
REQ-023 Counters SHALL not overflow: max points 2048*2048 fits 23 bits.

Reset
REQ-024 rst=1 at any time (including mid-scan with request outstanding) SHALL force IDLE and zero busy, done, req_valid, ptx, pty, pix_valid, pix_x, pix_y, inside_count.
REQ-025 After rst deasserts, no response arriving from an aborted request SHALL affect state.

Configuration
REQ-026 Macro RASTER_CLIP_EN defined: in BBOX xmax clamped to SCR_W-1 and ymax to SCR_H-1; if xmin>SCR_W-1 or ymin>SCR_H-1, no request issued, BBOX goes directly to DONE (done 2 cycles after start accept).
REQ-027 Macro RASTER_CLIP_EN undefined: no clamping; full 11-bit bounding box scanned; SCR_W/SCR_H unused.

Verification
REQ-028 Vertices (1,6),(4,14),(17,5), req_ready=1, responder rsp_inside=1 one cycle after each request -> 170 requests, first (1,5), last (17,14), inside_count=170, one done pulse.
REQ-029 Same triangle, responder returns true point-in-triangle result -> pix_valid only for interior points, (7,8) reported inside, inside_count equals pix_valid pulse count.
REQ-030 All vertices (3,3), req_ready held low 5 cycles -> ptx/pty=(3,3) stable while stalled, exactly one request, done after response.
REQ-031 rst pulsed while in WAIT, then rsp_valid=1 -> outputs all zero, state IDLE, inside_count stays 0; start while busy ignored.
REQ-032 RASTER_CLIP_EN, SCR_W=640: vertices (630,0),(700,0),(630,1) -> x scanned 630..639, y 0..1, 20 requests; vertices (700,0),(710,0),(705,5) -> zero requests, done 2 cycles after start.
